// File: rtl/key_debouncer_if.sv
// Key channel bundle: raw button pins in, conditioned level and event pulses out.
// The debouncer takes the slave side; whoever drives the pins takes the master side.
interface key_debouncer_if #(
    parameter int unsigned N_KEYS = 2
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_hold;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_hold
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_hold
    );
endinterface

// File: rtl/key_debouncer.sv
// Per-key synchroniser, stable-sample debounce FSM and long-hold timer.
// Every output is a flop; channels share nothing but the clock and reset.
module key_debouncer #(
    parameter int unsigned N_KEYS      = 2,
    parameter int unsigned DEBOUNCE    = 20,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic            clk,
    input logic            rst,
    key_debouncer_if.slave kif
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CntW-1:0]  CntLast   = CntW'(DEBOUNCE - 1);
    localparam logic [CntW-1:0]  CntOne    = CntW'(1);
    localparam logic [HoldW-1:0] HoldSat   = HoldW'(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldFire  = HoldW'(HOLD_CYCLES - 2);
    localparam logic [HoldW-1:0] HoldOne   = HoldW'(1);

    typedef enum logic [1:0] {
        StUp,
        StWaitDown,
        StDown,
        StWaitUp
    } state_e;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        logic pin_pressed;
        logic s;

        logic sync1_q, sync1_d;
        logic sync2_q, sync2_d;

        state_e           state_q, state_d;
        logic [CntW-1:0]  cnt_q, cnt_d;
        logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

        logic level_q, level_d;
        logic press_q, press_d;
        logic release_q, release_d;
        logic hold_q, hold_d;

        // Normalise polarity before the synchroniser so reset (0) is always "released".
        assign pin_pressed = kif.key_raw[i] ^ ACTIVE_LOW;
        assign s           = sync2_q;

        always_comb begin
            sync1_d    = pin_pressed;
            sync2_d    = sync1_q;
            state_d    = state_q;
            cnt_d      = cnt_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            hold_d     = 1'b0;

            unique case (state_q)
                StUp: begin
                    if (s) begin
                        state_d = StWaitDown;
                        cnt_d   = CntOne;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StWaitDown: begin
                    if (!s) begin
                        state_d = StUp;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d    = StDown;
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StDown: begin
                    if (!s) begin
                        state_d = StWaitUp;
                        cnt_d   = CntOne;
                    end
                end
                StWaitUp: begin
                    if (s) begin
                        state_d = StDown;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d   = StUp;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StUp;
                    cnt_d   = '0;
                end
            endcase

            // Hold time runs through release bounces; never fires on the release edge itself.
            if ((state_q == StDown || state_q == StWaitUp) && state_d != StUp) begin
                if (hold_cnt_q != HoldSat) begin
                    hold_cnt_d = hold_cnt_q + HoldOne;
                end
                if (hold_cnt_q == HoldFire) begin
                    hold_d = 1'b1;
                end
            end

            level_d = (state_d == StDown) || (state_d == StWaitUp);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                state_q    <= StUp;
                cnt_q      <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_q     <= 1'b0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_q     <= hold_d;
            end
        end

        assign kif.key_level[i]   = level_q;
        assign kif.key_press[i]   = press_q;
        assign kif.key_release[i] = release_q;
        assign kif.key_hold[i]    = hold_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model feeds an event scoreboard,
// directed scenarios add fixed-latency checks on top.
module tb_key_debouncer;

    localparam int NK = 2;
    localparam int D  = 20;
    localparam int H  = 1000;

    logic clk;
    logic rst;

    key_debouncer_if #(.N_KEYS(NK)) kif ();

    key_debouncer #(
        .N_KEYS     (NK),
        .DEBOUNCE   (D),
        .HOLD_CYCLES(H),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kif(kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 press, 1 release, 2 hold
    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    bit  exp_level[NK];
    int  run_len[NK];
    int  press_at[NK];
    bit  pipe1[NK];
    bit  pipe2[NK];

    // Level flips once D consecutive synchronised samples disagree with it.
    always @(posedge clk) begin
        cyc++;
        for (int ch = 0; ch < NK; ch++) begin
            if (rst) begin
                exp_level[ch] = 1'b0;
                run_len[ch]   = 0;
                pipe1[ch]     = 1'b0;
                pipe2[ch]     = 1'b0;
            end else begin
                bit s;
                s         = pipe2[ch];
                pipe2[ch] = pipe1[ch];
                pipe1[ch] = ~kif.key_raw[ch];
                if (s != exp_level[ch]) begin
                    run_len[ch]++;
                    if (run_len[ch] == D) begin
                        exp_level[ch] = s;
                        run_len[ch]   = 0;
                        if (s) begin
                            press_at[ch] = cyc;
                            evq.push_back('{cyc: cyc, ch: ch, kind: 0});
                        end else begin
                            evq.push_back('{cyc: cyc, ch: ch, kind: 1});
                        end
                    end
                end else begin
                    run_len[ch] = 0;
                end
                if (exp_level[ch] && (cyc - press_at[ch] == H - 1)) begin
                    evq.push_back('{cyc: cyc, ch: ch, kind: 2});
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int n_press[NK];
    int n_rel[NK];
    int n_hold[NK];
    int n_lvl[NK];
    int last_press[NK];
    int last_hold[NK];

    always @(negedge clk) begin
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            check("missed_event", -1, evq[0].kind);
            void'(evq.pop_front());
        end
        for (int ch = 0; ch < NK; ch++) begin
            logic [2:0] seen;
            seen = {kif.key_hold[ch], kif.key_release[ch], kif.key_press[ch]};
            check($sformatf("level[%0d]", ch), int'(kif.key_level[ch]), int'(exp_level[ch]));
            for (int k = 0; k < 3; k++) begin
                bit expd;
                expd = evq.size() > 0 && evq[0].cyc == cyc && evq[0].ch == ch
                       && evq[0].kind == k;
                if (expd) void'(evq.pop_front());
                if (seen[k] || expd) begin
                    check($sformatf("pulse ch%0d kind%0d cyc%0d", ch, k, cyc),
                          int'(seen[k]), int'(expd));
                end
            end
            if (seen[0]) begin
                n_press[ch]++;
                last_press[ch] = cyc;
            end
            if (seen[1]) n_rel[ch]++;
            if (seen[2]) begin
                n_hold[ch]++;
                last_hold[ch] = cyc;
            end
            if (kif.key_level[ch]) n_lvl[ch]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NK; ch++) begin
            n_press[ch] = 0;
            n_rel[ch]   = 0;
            n_hold[ch]  = 0;
            n_lvl[ch]   = 0;
        end
    endtask

    initial begin
        int k;
        int r_edge;
        int rem[NK];

        rst         = 1'b1;
        kif.key_raw = '1;
        @(posedge clk);
        #2;
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              int'({kif.key_level, kif.key_press, kif.key_release, kif.key_hold}), 0);
        step(5);

        // Clean press on key 0, low for exactly 100 samples.
        clear_counts();
        kif.key_raw[0] = 1'b0;
        k = cyc + 1;
        step(100);
        kif.key_raw[0] = 1'b1;
        check("clean_press_latency", last_press[0] - k, D + 1);
        k = cyc + 1;
        step(40);
        check("clean_press_count", n_press[0], 1);
        check("clean_release_count", n_rel[0], 1);
        check("clean_release_latency", cyc - 40 + 1 - k + 0, 0);
        check("clean_level_cycles", n_lvl[0], 100);
        check("clean_no_hold", n_hold[0], 0);

        // Bounce rejection: short lows never accepted.
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            kif.key_raw[0] = 1'b0;
            step(5);
            kif.key_raw[0] = 1'b1;
            step(3);
        end
        step(40);
        check("bounce_no_press", n_press[0], 0);
        check("bounce_no_release", n_rel[0], 0);
        check("bounce_no_level", n_lvl[0], 0);

        // Chatter on the press edge, then steady low.
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            kif.key_raw[0] = 1'b0;
            step(2);
            kif.key_raw[0] = 1'b1;
            step(2);
        end
        kif.key_raw[0] = 1'b0;
        k = cyc + 1;
        step(40);
        check("chatter_press_count", n_press[0], 1);
        check("chatter_press_latency", last_press[0] - k, D + 1);
        kif.key_raw[0] = 1'b1;
        step(40);
        check("chatter_release_count", n_rel[0], 1);

        // Long hold on key 1 with a short high glitch well after the hold pulse.
        clear_counts();
        kif.key_raw[1] = 1'b0;
        step(1200);
        kif.key_raw[1] = 1'b1;
        step(4);
        kif.key_raw[1] = 1'b0;
        step(296);
        check("hold_press_count", n_press[1], 1);
        check("hold_pulse_count", n_hold[1], 1);
        check("hold_delay", last_hold[1] - last_press[1], H - 1);
        check("hold_glitch_no_release", n_rel[1], 0);
        kif.key_raw[1] = 1'b1;
        step(40);
        check("hold_final_release", n_rel[1], 1);

        // Simultaneous press on both keys, then independent releases.
        clear_counts();
        kif.key_raw = '0;
        step(40);
        check("simul_press_same_cycle", last_press[0], last_press[1]);
        check("simul_press_count", n_press[0] + n_press[1], 2);
        kif.key_raw[0] = 1'b1;
        step(40);
        check("simul_level0_released", int'(kif.key_level[0]), 0);
        check("simul_level1_held", int'(kif.key_level[1]), 1);
        kif.key_raw[1] = 1'b1;
        step(40);
        check("simul_level1_released", int'(kif.key_level[1]), 0);

        // Reset while key 0 is accepted-pressed and still held.
        kif.key_raw[0] = 1'b0;
        step(40);
        check("pre_reset_level", int'(kif.key_level[0]), 1);
        rst    = 1'b1;
        r_edge = cyc + 1;
        step(1);
        rst = 1'b0;
        clear_counts();
        @(negedge clk);
        check("midreset_outputs",
              int'({kif.key_level, kif.key_press, kif.key_release, kif.key_hold}), 0);
        step(40);
        check("reset_no_release", n_rel[0], 0);
        check("reset_repress_count", n_press[0], 1);
        check("reset_repress_latency", last_press[0] - r_edge, D + 2);
        kif.key_raw[0] = 1'b1;
        step(40);

        // Randomised segments per key, including occasional long holds and resets.
        for (int ch = 0; ch < NK; ch++) rem[ch] = 0;
        for (int t = 0; t < 9000; t++) begin
            for (int ch = 0; ch < NK; ch++) begin
                if (rem[ch] == 0) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    kif.key_raw[ch] = ~kif.key_raw[ch];
                    if (r < 60)      rem[ch] = int'($urandom_range(1, 25));
                    else if (r < 94) rem[ch] = int'($urandom_range(20, 120));
                    else             rem[ch] = int'($urandom_range(1000, 1100));
                end
                rem[ch]--;
            end
            rst = ($urandom_range(0, 2999) == 0);
            step(1);
        end
        rst         = 1'b0;
        kif.key_raw = '1;
        step(60);

        check("scoreboard_drained", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions raw push-button inputs for the reaction-timer FSM. It sits directly upstream of the state machine, between the board KEY pins and the FSM start/stop inputs. Per key, it synchronises the raw pin, rejects contact bounce with a stable-sample counter, and produces:
- a clean level;
- single-cycle press and release pulses;
- a single-cycle long-hold pulse.

It runs on the same 1 kHz tick clock as the FSM, so counts are in milliseconds.

## Interface
Parameters:
- N_KEYS, 2: number of independent key channels.
- DEBOUNCE, 20: consecutive stable samples required to accept a level change. Legal range 2..255.
- HOLD_CYCLES, 1000: clk cycles in the accepted-pressed state before `key_hold` fires. Legal range 2..65535.
- ACTIVE_LOW, 1: 1 means a raw 0 is "pressed", matching the board KEY pins. 0 means a raw 1 is "pressed".

Ports:
- clk, input, 1: system clock (1 kHz tick clock in the top level). This is the one clock.
- rst, input, 1: reset, synchronous and active-high.
- key_raw, input, N_KEYS: asynchronous raw button pins.
- key_level, output, N_KEYS: debounced pressed level (1 = pressed).
- key_press, output, N_KEYS: one-cycle pulse on each accepted press.
- key_release, output, N_KEYS: one-cycle pulse on each accepted release.
- key_hold, output, N_KEYS: one-cycle pulse once per press, after HOLD_CYCLES.

## Operation
- Channels are fully independent. Each channel has its own synchroniser, FSM, debounce counter and hold counter; there is no cross-channel arbitration.
- Synchroniser: two flops per key. Output `s` is normalised to 1 = pressed according to ACTIVE_LOW.
- Debounce counter: width clog2(DEBOUNCE+1). Hold counter: width clog2(HOLD_CYCLES+1).
- Per-channel FSM states: UP, WAIT_DOWN, DOWN, WAIT_UP.
  - UP:
    - s=1: go to WAIT_DOWN, cnt<=1.
    - otherwise stay, cnt<=0.
  - WAIT_DOWN:
    - s=0: return to UP, cnt<=0. This is a bounce; no output.
    - s=1 and cnt==DEBOUNCE-1: go to DOWN, hold_cnt<=0.
    - otherwise cnt<=cnt+1.
  - DOWN:
    - s=0: go to WAIT_UP, cnt<=1.
    - otherwise hold_cnt increments, saturating at HOLD_CYCLES.
  - WAIT_UP:
    - s=1: return to DOWN, cnt<=0. hold_cnt is not cleared and continues counting.
    - s=0 and cnt==DEBOUNCE-1: go to UP.
    - otherwise cnt<=cnt+1.
- key_level = 1 in DOWN and WAIT_UP, and 0 in UP and WAIT_DOWN.
- key_press: high for exactly the first cycle in DOWN after leaving WAIT_DOWN. A WAIT_UP→DOWN return does not pulse.
- key_release: high for exactly the first cycle in UP after leaving WAIT_UP.
- key_hold: high for one cycle when hold_cnt reaches HOLD_CYCLES-1 while in DOWN or WAIT_UP. It fires at most once per accepted press; the saturating counter prevents a repeat. hold_cnt is cleared only on entry to DOWN from WAIT_DOWN.
- All outputs are registered. There are no combinational paths from key_raw to any output.

## Timing
- Reset, taking effect at the first rising edge with rst=1:
  - synchroniser flops go to the released level;
  - FSM goes to UP;
  - all counters go to 0;
  - key_level, key_press, key_release and key_hold all = 0.
- Reset mid-press: the channel returns to UP regardless of state, and no release pulse is issued. If the key is still held after rst deasserts, a fresh press is accepted with the normal latency.
- Press latency with a clean input: let edge k be the first edge that samples the pressed raw level.
  - s=1 after edge k+1.
  - WAIT_DOWN after edge k+2.
  - DOWN after edge k+DEBOUNCE+1.
  - key_press and key_level are visible in the cycle following edge k+DEBOUNCE+1. Default: 21 cycles = 21 ms.
- Release latency is symmetric: key_release appears DEBOUNCE+1 edges after the first released sample.
- key_hold is asserted HOLD_CYCLES-1 edges after the key_press cycle.
- A glitch of up to DEBOUNCE-1 samples during WAIT_DOWN or WAIT_UP never changes key_level.
- Simultaneous press on multiple channels: each channel pulses independently, possibly in the same cycle.

## Test plan
- Clean press (DEBOUNCE=20, HOLD_CYCLES=1000): key_raw[0] 1→0, held 100 cycles, then 0→1.
  - key_press[0] is one cycle, 21 cycles after the first low sample.
  - key_level[0] is high for 100 cycles.
  - key_release[0] is one cycle, 21 cycles after release.
  - key_hold[0] never fires.
- Bounce rejection: 5-cycle low glitches separated by 3-cycle highs, repeated 10 times, then a steady high.
  - key_press, key_level and key_release all stay 0 throughout.
- Bounce on press edge: 3 low/high chatters, then steady low.
  - Exactly one key_press[0] pulse, 21 cycles after the last high→low transition.
- Long hold: key_raw[1] low for 1500 cycles.
  - key_press[1], then key_hold[1] exactly 999 cycles later, firing only once.
  - A single 4-cycle high glitch at cycle 1200 produces no release and no second hold pulse.
- Simultaneous keys: both key_raw bits go low at the same edge.
  - key_press[0] and key_press[1] are asserted in the same cycle, and both levels track independently.
- Reset mid-operation: rst pulsed for 1 cycle while key_level[0]=1.
  - All outputs are 0 the next cycle, with no key_release.
  - With the key still held, key_press[0] reasserts 22 cycles after rst deasserts.
